// File: rtl/swipt_monitor.sv
// SWIPT receive-path front-end monitor.
// Qualifies the heartbeat toggle into a registered link-alive flag and turns
// the 12-bit ADC stream into a hysteretic comparator with a rising-edge pulse.
// Both comparator outputs are held low while the link is not alive.
module swipt_monitor #(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned MID     = 2048,
    parameter int unsigned HYST    = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        heartbeat_in,
    input  logic [11:0] adc_in,
    output logic        swipt_alive,
    output logic        adc_comp,
    output logic        comp_edge
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [12:0] HI        = 13'(MID + HYST);
    localparam logic [12:0] LO        = 13'(MID - HYST);

    logic        hb_s1;
    logic        hb_s2;
    logic        hb_prev;
    logic        hb_edge;
    logic [15:0] timer;
    logic [15:0] timer_next;
    logic [1:0]  edge_cnt;
    logic [1:0]  edge_cnt_next;
    logic        alive_next;
    logic [11:0] adc_q;
    logic        comp_next;

    // Heartbeat edge detect, timeout timer and edge qualification (next state)
    always_comb begin
        hb_edge       = hb_s2 ^ hb_prev;
        timer_next    = timer;
        edge_cnt_next = edge_cnt;
        if (hb_edge) begin
            // An edge always wins over a simultaneous timeout
            timer_next    = '0;
            edge_cnt_next = (edge_cnt == 2'd2) ? 2'd2 : edge_cnt + 2'd1;
        end else begin
            timer_next    = (timer >= TIMEOUT_W) ? TIMEOUT_W : timer + 16'd1;
            edge_cnt_next = (timer_next == TIMEOUT_W) ? 2'd0 : edge_cnt;
        end
        alive_next = (edge_cnt_next == 2'd2) && (timer_next < TIMEOUT_W);
    end

    // Hysteretic comparator next value, forced low while the link is down
    always_comb begin
        comp_next = 1'b0;
        if (swipt_alive) begin
            if ({1'b0, adc_q} >= HI)
                comp_next = 1'b1;
            else if ({1'b0, adc_q} <= LO)
                comp_next = 1'b0;
            else
                comp_next = adc_comp;
        end
    end

    // All state registers; asynchronous active-high clear
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            hb_s1       <= 1'b0;
            hb_s2       <= 1'b0;
            hb_prev     <= 1'b0;
            timer       <= '0;
            edge_cnt    <= '0;
            swipt_alive <= 1'b0;
            adc_q       <= '0;
            adc_comp    <= 1'b0;
            comp_edge   <= 1'b0;
        end else begin
            hb_s1       <= heartbeat_in;
            hb_s2       <= hb_s1;
            hb_prev     <= hb_s2;
            timer       <= timer_next;
            edge_cnt    <= edge_cnt_next;
            swipt_alive <= alive_next;
            adc_q       <= adc_in;
            adc_comp    <= comp_next;
            comp_edge   <= swipt_alive & comp_next & ~adc_comp;
        end
    end

endmodule

// File: tb/tb_swipt_monitor.sv
// Self-checking bench for swipt_monitor: heartbeat qualification, timeout,
// hysteresis boundaries, sine tracking, gating and asynchronous reset.
module tb_swipt_monitor;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        heartbeat_in = 1'b0;
    logic [11:0] adc_in = '0;
    logic        swipt_alive;
    logic        adc_comp;
    logic        comp_edge;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // heartbeat generator control
    logic hb_en    = 1'b0;
    int   hb_cnt   = 0;
    int   hb_tcount = 0;

    typedef struct {
        int    due;
        logic  comp;
        logic  edg;
        string tag;
    } exp_t;
    exp_t sb[$];

    swipt_monitor #(.TIMEOUT(200), .MID(2048), .HYST(64)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .heartbeat_in (heartbeat_in),
        .adc_in       (adc_in),
        .swipt_alive  (swipt_alive),
        .adc_comp     (adc_comp),
        .comp_edge    (comp_edge)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Free-running heartbeat: toggles every 90 clk while enabled
    initial forever begin
        @(posedge clk);
        #2;
        if (hb_en) begin
            if (hb_cnt == 89) begin
                heartbeat_in = ~heartbeat_in;
                hb_cnt = 0;
                hb_tcount++;
            end else begin
                hb_cnt++;
            end
        end
    end

    // Scoreboard: compare queued comparator expectations when they fall due
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                check_val({e.tag, "_due"}, cyc, e.due);
            end else begin
                check_val({e.tag, "_comp"}, adc_comp, e.comp);
                check_val({e.tag, "_edge"}, comp_edge, e.edg);
            end
        end
    end

    // Wait (bounded) for the generator's next heartbeat transition;
    // returns on the negedge following the transition's posedge.
    task automatic wait_transition(input string tag);
        int start;
        start = hb_tcount;
        for (int i = 0; i < 300 && hb_tcount == start; i++) @(negedge clk);
        check_val(tag, hb_tcount - start, 1);
    endtask

    function automatic logic [11:0] sine_sample(input int n);
        real v;
        v = 2048.0 + 1500.0 * $sin(2.0 * PI * n / 200.0);
        return 12'($rtoi($floor(v + 0.5)));
    endfunction

    initial begin
        int hys_v[7];
        logic hys_c[7];
        int last_edge, n_edges, high;
        hys_v = '{2048, 2111, 2112, 2100, 1985, 1984, 2000};
        hys_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held with activity on inputs
        adc_in = 12'hFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            heartbeat_in = ~heartbeat_in;
            check_val("rst_hold", {swipt_alive, adc_comp, comp_edge}, 0);
        end
        heartbeat_in = 1'b0;
        adc_in = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("post_rst", {swipt_alive, adc_comp, comp_edge}, 0);
        end

        // Alive qualification
        hb_cnt = 0;
        hb_en  = 1'b1;
        wait_transition("hb_first");
        repeat (10) @(negedge clk);
        check_val("single_edge_alive", swipt_alive, 0);
        wait_transition("hb_second");
        @(negedge clk); check_val("alive_k1", swipt_alive, 0);
        @(negedge clk); check_val("alive_k2", swipt_alive, 0);
        @(negedge clk); check_val("alive_k3", swipt_alive, 1);
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(negedge clk);
            check_val("alive_stay", swipt_alive, 1);
        end

        // Timeout: drop exactly 200 clk after the last registered edge
        wait_transition("hb_last");
        hb_en = 1'b0;
        repeat (202) @(negedge clk);
        check_val("to_before", swipt_alive, 1);
        @(negedge clk);
        check_val("to_drop", swipt_alive, 0);
        repeat (5) @(negedge clk);
        heartbeat_in = ~heartbeat_in;
        repeat (20) @(negedge clk);
        check_val("to_single", swipt_alive, 0);
        heartbeat_in = ~heartbeat_in;
        repeat (2) @(negedge clk);
        check_val("requal_k2", swipt_alive, 0);
        @(negedge clk);
        check_val("requal_k3", swipt_alive, 1);
        hb_cnt = 0;
        hb_en  = 1'b1;

        // Hysteresis boundaries via scoreboard (2-cycle latency)
        adc_in = 12'd2048;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            adc_in = 12'(hys_v[i]);
            sb.push_back('{cyc + 2, hys_c[i], (i == 2), $sformatf("hys%0d", i)});
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_val("sb_drain", sb.size(), 0);

        // Sine tracking
        last_edge = -1;
        n_edges   = 0;
        high      = 0;
        for (int n = 0; n < 1200; n++) begin
            adc_in = sine_sample(n);
            @(negedge clk);
            if (comp_edge) begin
                if (last_edge >= 0) check_val("sine_period", cyc - last_edge, 200);
                last_edge = cyc;
                n_edges++;
            end
            if (n >= 400 && n < 1000 && adc_comp) high++;
        end
        check_val("sine_edges", n_edges, 6);
        check_val("sine_duty", (high >= 297 && high <= 303), 1);
        check_val("sine_alive", swipt_alive, 1);

        // Gating: comparator clears one edge after alive drops
        adc_in = 12'hFFF;
        repeat (3) @(negedge clk);
        check_val("gate_pre", adc_comp, 1);
        wait_transition("hb_gate");
        hb_en = 1'b0;
        repeat (202) @(negedge clk);
        check_val("gate_alive_hi", swipt_alive, 1);
        @(negedge clk);
        check_val("gate_alive_lo", swipt_alive, 0);
        check_val("gate_comp_hold", adc_comp, 1);
        @(negedge clk);
        check_val("gate_comp_clr", {adc_comp, comp_edge}, 0);
        repeat (5) @(negedge clk);
        check_val("gate_comp_stay", {adc_comp, comp_edge}, 0);

        // Requalify with input high: comparator restarts from 0 and pulses
        heartbeat_in = ~heartbeat_in;
        repeat (10) @(negedge clk);
        heartbeat_in = ~heartbeat_in;
        repeat (3) @(negedge clk);
        check_val("restart_alive", {swipt_alive, adc_comp}, 2'b10);
        @(negedge clk);
        check_val("restart_rise", {adc_comp, comp_edge}, 2'b11);
        @(negedge clk);
        check_val("restart_pulse_end", {adc_comp, comp_edge}, 2'b10);
        hb_cnt = 0;
        hb_en  = 1'b1;

        // Asynchronous reset mid-sine
        adc_in = sine_sample(150);
        repeat (4) @(negedge clk);
        begin
            int n;
            n = 0;
            for (int i = 0; i < 400 && !adc_comp; i++) begin
                adc_in = sine_sample(n);
                n++;
                @(negedge clk);
            end
        end
        check_val("midsine_comp", adc_comp, 1);
        #1 nrst = 1'b1;
        #1 check_val("async_rst", {swipt_alive, adc_comp, comp_edge}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("async_rst_hold", {swipt_alive, adc_comp, comp_edge}, 0);
        end
        hb_en = 1'b0;
        nrst  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("post_rst2", {swipt_alive, adc_comp, comp_edge}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
